// File: rtl/cmd_dispatch_pkg.sv
// cmd_dispatch_pkg: shared types and constants for the command sequencer.
// Opcodes, response bytes, FSM states and cmd field positions.
package cmd_dispatch_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;

  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned ADDR_HI = 11;
  localparam int unsigned ADDR_LO = 8;
  localparam int unsigned DATA_HI = 7;
  localparam int unsigned DATA_LO = 0;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [3:0] {
    OP_WR = 4'h1,
    OP_RD = 4'h2,
    OP_GO = 4'h3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC_WAIT,
    RESP,
    RESP_WAIT
  } state_e;

endpackage

// File: rtl/cmd_dispatch_if.sv
// cmd_dispatch_if: UART_wrapper <-> cmd_dispatch command/response link.
// master = UART_wrapper side, slave = cmd_dispatch side.
interface cmd_dispatch_if;
  import cmd_dispatch_pkg::*;

  logic              cmd_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [RESP_W-1:0] resp;
  logic              resp_sent;

  modport master (
    output cmd_rdy,
    output cmd,
    output resp_sent,
    input  clr_cmd_rdy,
    input  send_resp,
    input  resp
  );

  modport slave (
    input  cmd_rdy,
    input  cmd,
    input  resp_sent,
    output clr_cmd_rdy,
    output send_resp,
    output resp
  );

endinterface

// File: rtl/cmd_timer.sv
// cmd_timer: loadable saturating down-counter for the GO timeout.
// Ports: clk, rst_n, load_i, en_i in; expired_o high while count is 0.
module cmd_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: one-command/one-response sequencer behind UART_wrapper.
// Ports: uart (slave link), go_o/go_arg_o/go_done_i exec, cfg_regs_o, busy_o.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmd_dispatch_if.slave         uart,
  output logic                  go_o,
  output logic [11:0]           go_arg_o,
  input  logic                  go_done_i,
  output logic [NUM_REGS*8-1:0] cfg_regs_o,
  output logic                  busy_o
);

  localparam int unsigned AW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e      state_q;
  logic [15:0] cmd_q;
  logic [7:0]  resp_q;
  logic [11:0] go_arg_q;
  logic [7:0]  cfg_q [NUM_REGS];

  logic [3:0]    op;
  logic [3:0]    addr;
  logic [7:0]    data;
  logic          addr_ok;
  logic [AW-1:0] idx;
  logic          is_go;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_exp;

  assign op      = cmd_q[OP_HI:OP_LO];
  assign addr    = cmd_q[ADDR_HI:ADDR_LO];
  assign data    = cmd_q[DATA_HI:DATA_LO];
  assign addr_ok = 32'(addr) < NUM_REGS;
  assign idx     = addr[AW-1:0];
  assign is_go   = (op == OP_GO);

  assign tmr_load = (state_q == DECODE) && is_go;
  assign tmr_en   = (state_q == EXEC_WAIT);

  cmd_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      resp_q   <= '0;
      go_arg_q <= '0;
      cfg_q    <= '{default: '0};
    end else begin
      unique case (state_q)
        IDLE: begin
          if (uart.cmd_rdy) begin
            cmd_q   <= uart.cmd;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          state_q <= RESP;
          unique case (1'b1)
            (op == OP_WR) && addr_ok: begin
              cfg_q[idx] <= data;
              resp_q     <= ACK;
            end
            (op == OP_RD) && addr_ok: begin
              resp_q <= cfg_q[idx];
            end
            is_go: begin
              go_arg_q <= cmd_q[11:0];
              state_q  <= EXEC_WAIT;
            end
            default: begin
              resp_q <= NAK;
            end
          endcase
        end
        EXEC_WAIT: begin
          // completion beats a same-cycle expiry
          if (go_done_i) begin
            resp_q  <= ACK;
            state_q <= RESP;
          end else if (tmr_exp) begin
            resp_q  <= NAK;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= RESP_WAIT;
        end
        RESP_WAIT: begin
          if (uart.resp_sent) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // consume in the same cycle the command is latched
  assign uart.clr_cmd_rdy =
    rst_n && (state_q == IDLE) && uart.cmd_rdy;
  assign uart.send_resp = (state_q == RESP);
  // resp_q is settled before RESP and held through RESP_WAIT
  assign uart.resp      = resp_q;
  assign go_o           = tmr_load;
  assign go_arg_o       = go_arg_q;
  assign busy_o         = (state_q != IDLE);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
    assign cfg_regs_o[8*i +: 8] = cfg_q[i];
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed host-level bench for cmd_dispatch.
// Models UART_wrapper handshakes and an exec-unit stub.
module tb_cmd_dispatch;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go;
  logic        go_done;
  logic [11:0] go_arg;
  logic [63:0] cfg;
  logic        busy;

  cmd_dispatch_if u();

  cmd_dispatch #(
    .NUM_REGS   (8),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart      (u),
    .go_o      (go),
    .go_arg_o  (go_arg),
    .go_done_i (go_done),
    .cfg_regs_o(cfg),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int sr_cnt = 0;
  int go_cnt = 0;
  int clr_cyc = 0;
  int sr_cyc = 0;
  int go_cyc = 0;
  int rs_cyc = 0;
  int stub_delay = -1;
  logic [7:0]  rq[$];
  logic [63:0] exp_cfg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u.clr_cmd_rdy === 1'b1) begin
      clr_cnt <= clr_cnt + 1;
      clr_cyc <= cyc;
    end
    if (u.send_resp === 1'b1) begin
      sr_cnt <= sr_cnt + 1;
      sr_cyc <= cyc;
    end
    if (go === 1'b1) begin
      go_cnt <= go_cnt + 1;
      go_cyc <= cyc;
    end
    if (u.resp_sent === 1'b1) rs_cyc <= cyc;
  end

  // UART_wrapper transmit side: 3-cycle byte time
  initial begin
    logic [7:0] r;
    u.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (u.send_resp === 1'b1) begin
        r = u.resp;
        repeat (3) @(posedge clk);
        #1 u.resp_sent = 1'b1;
        @(posedge clk);
        #1 u.resp_sent = 1'b0;
        rq.push_back(r);
      end
    end
  end

  // exec-unit stub: go_done pulse stub_delay cycles after go
  initial begin
    go_done = 1'b0;
    forever begin
      @(negedge clk);
      if (go === 1'b1 && stub_delay > 0) begin
        repeat (stub_delay) @(posedge clk);
        #1 go_done = 1'b1;
        @(posedge clk);
        #1 go_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snd_cmd(input logic [15:0] c);
    int n = 0;
    @(posedge clk);
    #1;
    u.cmd = c;
    u.cmd_rdy = 1'b1;
    @(negedge clk);
    while (u.clr_cmd_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (u.clr_cmd_rdy !== 1'b1) chk("clr_timeout", 0, 1);
    @(posedge clk);
    #1;
    u.cmd_rdy = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [7:0] exp);
    int n = 0;
    logic [7:0] r;
    while (rq.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      r = rq.pop_front();
      chk(tag, 64'(r), 64'(exp));
    end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, g0, d;
    u.cmd_rdy = 1'b0;
    u.cmd = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_go", 64'(go), 0);
    chk("rst_go_arg", 64'(go_arg), 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_resp", 64'(u.resp), 0);
    chk("rst_send_resp", 64'(u.send_resp), 0);
    chk("rst_clr", 64'(u.clr_cmd_rdy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    c0 = clr_cnt;
    s0 = sr_cnt;
    snd_cmd(16'h1234);
    get_resp("wr2_ack", 8'hA5);
    exp_cfg[23:16] = 8'h34;
    chk("wr2_cfg", cfg, exp_cfg);
    chk("wr2_clr_pulses", 64'(clr_cnt - c0), 1);
    chk("wr2_sr_pulses", 64'(sr_cnt - s0), 1);
    chk("wr2_latency", 64'(sr_cyc - clr_cyc), 2);

    snd_cmd(16'h2200);
    get_resp("rd2", 8'h34);
    snd_cmd(16'h2500);
    get_resp("rd5", 8'h00);
    snd_cmd(16'h2900);
    get_resp("rd9_nak", 8'hEE);
    snd_cmd(16'h1834);
    get_resp("wr8_nak", 8'hEE);
    chk("wr8_cfg_kept", cfg, exp_cfg);
    snd_cmd(16'h17C3);
    get_resp("wr7_ack", 8'hA5);
    exp_cfg[63:56] = 8'hC3;
    chk("wr7_cfg", cfg, exp_cfg);
    snd_cmd(16'h2700);
    get_resp("rd7", 8'hC3);

    g0 = go_cnt;
    stub_delay = 10;
    snd_cmd(16'h3ABC);
    get_resp("go_ack", 8'hA5);
    chk("go_pulses", 64'(go_cnt - g0), 1);
    chk("go_arg", 64'(go_arg), 64'h0ABC);
    chk("go_latency", 64'(sr_cyc - go_cyc), 11);

    stub_delay = -1;
    snd_cmd(16'h3001);
    get_resp("go_timeout_nak", 8'hEE);
    d = sr_cyc - go_cyc;
    chk("timeout_latency", 64'(d >= T + 1 && d <= T + 2), 1);
    chk("timeout_go_arg", 64'(go_arg), 64'h001);

    stub_delay = T + 1;
    snd_cmd(16'h3002);
    get_resp("go_on_expiry_ack", 8'hA5);

    stub_delay = -1;
    snd_cmd(16'hF000);
    snd_cmd(16'h2200);
    chk("ovl_clr_after_sent", 64'(clr_cyc), 64'(rs_cyc + 1));
    get_resp("ovl_illegal_nak", 8'hEE);
    get_resp("ovl_rd2", 8'h34);

    snd_cmd(16'h3123);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_go_arg", 64'(go_arg), 0);
    chk("mid_rst_cfg", cfg, 0);
    chk("mid_rst_resp", 64'(u.resp), 0);
    chk("mid_rst_send_resp", 64'(u.send_resp), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cfg = '0;

    snd_cmd(16'h2000);
    get_resp("post_rst_rd0", 8'h00);
    snd_cmd(16'h2200);
    get_resp("post_rst_rd2", 8'h00);
    chk("post_rst_cfg", cfg, exp_cfg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
Slave-side command sequencer that sits directly behind UART_wrapper. It consumes each received 16-bit command and decodes it. It then executes the command against a local config register bank or an external motion/execution unit, and returns exactly one 8-bit response through UART_wrapper. It owns the cmd_rdy/clr_cmd_rdy and send_resp/resp_sent handshakes, so the host (CommMaster side) sees strict one-command, one-response ordering.

Parameters:
NUM_REGS, 8, number of 8-bit config registers (addressable via cmd[11:8]; must be <=16)
TIMEOUT_CYC, 1000000, clk cycles allowed between go pulse and go_done before NAK

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
cmd_rdy  input  1  UART_wrapper: 16-bit command available
cmd  input  16  UART_wrapper: received command
resp_sent  input  1  UART_wrapper: response byte fully transmitted (pulse)
clr_cmd_rdy  output  1  to UART_wrapper: consume current command (1-cycle pulse)
send_resp  output  1  to UART_wrapper: start response transmit (1-cycle pulse)
resp  output  8  to UART_wrapper: response byte, stable from send_resp until resp_sent
go  output  1  to exec unit: start operation (1-cycle pulse)
go_arg  output  12  to exec unit: operand cmd[11:0], held until next GO
go_done  input  1  from exec unit: operation finished (pulse or level)
cfg_regs  output  NUM_REGS*8  flattened config registers, reg i at [8i+7:8i]
busy  output  1  high whenever state != IDLE

Behaviour:
- Command format: cmd[15:12] opcode, cmd[11:8] addr, cmd[7:0] data.
- Opcodes: 4'h1 WR, 4'h2 RD, 4'h3 GO. All others are illegal.
- Response constants: ACK 8'hA5, NAK 8'hEE.
- Reset (async, rst_n low): state IDLE. clr_cmd_rdy, send_resp, go, busy are 0; resp 8'h00; go_arg 12'h000; all cfg_regs 8'h00; timer 0. Reset mid-operation abandons the command with no response. A command still pending in UART_wrapper is served after reset releases.
- IDLE: when cmd_rdy=1, latch cmd into cmd_q, pulse clr_cmd_rdy for exactly that cycle, go to DECODE. While not in IDLE, cmd_rdy is ignored and no clr_cmd_rdy is issued; the command stays pending in UART_wrapper.
- DECODE (one cycle):
  - WR with addr<NUM_REGS: cfg_regs[addr] <= data (visible the next cycle); resp_q = ACK.
  - WR with addr>=NUM_REGS: no write; resp_q = NAK.
  - RD with addr<NUM_REGS: resp_q = cfg_regs[addr]. RD with addr>=NUM_REGS: resp_q = NAK.
  - GO: pulse go for 1 cycle; go_arg <= cmd_q[11:0]; load timer with TIMEOUT_CYC; go to EXEC_WAIT.
  - Illegal opcode: resp_q = NAK.
  - Every non-GO case goes to RESP.
- EXEC_WAIT: timer decrements each cycle.
  - go_done=1: resp_q = ACK, go to RESP.
  - Otherwise, timer==0: resp_q = NAK, go to RESP.
  - go_done and expiry in the same cycle: ACK wins.
  - go_done is sampled only in EXEC_WAIT; a go_done arriving in any other state is ignored.
- RESP: resp <= resp_q, send_resp pulsed 1 cycle, go to RESP_WAIT.
- RESP_WAIT: resp held constant. On resp_sent go to IDLE.
- Back-to-back: the earliest clr_cmd_rdy for the next command is the cycle after resp_sent.
- Latency:
  - WR/RD/illegal: cmd_rdy sampled (cycle 0) -> send_resp at cycle 2.
  - GO: go at cycle 1; send_resp 2 cycles after go_done is sampled... precisely, send_resp is the cycle after the EXEC_WAIT exit cycle.
- Timer width: $clog2(TIMEOUT_CYC+1), saturating at 0, never wraps.

Decomposition:
- Package cmd_dispatch_pkg holds:
  - opcode enum (OP_WR, OP_RD, OP_GO)
  - ACK/NAK localparams
  - state enum (IDLE, DECODE, EXEC_WAIT, RESP, RESP_WAIT)
  - field-slice localparams for the cmd layout
- One sub-module, cmd_timer: a loadable down-counter with load, en, and expired outputs, parameterized by TIMEOUT_CYC.
- FSM, decode and register bank stay in cmd_dispatch.

Test Plan:
- Host-level bench: CommMaster -> UART_wrapper -> cmd_dispatch, with TIMEOUT_CYC=50.
- Config write: snd_cmd 16'h1234 (WR reg2 <- 8'h34) -> resp_rcvd 8'hA5; cfg_regs[23:16]==8'h34; exactly one clr_cmd_rdy and one send_resp pulse.
- Readback: after the write above, send 16'h2200 -> resp_rcvd 8'h34. Send 16'h2500 on untouched reg5 -> 8'h00. Send 16'h2900 (addr 9 >= NUM_REGS) -> 8'hEE.
- GO completes: send 16'h3ABC; the stub asserts go_done 10 cycles after go -> go pulses once, go_arg==12'hABC, resp 8'hA5.
- GO timeout: send 16'h3001; the stub never asserts go_done -> send_resp issued 51-52 cycles after go, resp 8'hEE.
  - Also drive go_done exactly on the expiry cycle -> 8'hA5.
- Illegal opcode and overlap: send 16'hF000 -> 8'hEE. Issue a second command while in RESP_WAIT -> no clr_cmd_rdy until after resp_sent; both responses arrive in order.
- Reset mid-GO: drop rst_n during EXEC_WAIT -> all outputs at reset values immediately and busy=0. A following 16'h2000 -> 8'h00, because the registers were cleared.
